// File: rtl/iir_pkg.sv
// Shared constants, types and helpers for the TDM biquad.
// Tap order, coefficient addresses, FSM states, output rounding.
package iir_pkg;

  localparam int NTAP = 5;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  localparam logic [2:0] ADDR_B0 = 3'd0;
  localparam logic [2:0] ADDR_B1 = 3'd1;
  localparam logic [2:0] ADDR_B2 = 3'd2;
  localparam logic [2:0] ADDR_A1 = 3'd3;
  localparam logic [2:0] ADDR_A2 = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } rnd_t;

  // Round half up, drop frac bits, clip to a dw-bit signed range.
  function automatic rnd_t sat_round(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd_t               o;
    r     = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (dw - 1));
    o.sat = 1'b0;
    o.val = r;
    if (r > hi) begin
      o.sat = 1'b1;
      o.val = hi;
    end else if (r < lo) begin
      o.sat = 1'b1;
      o.val = lo;
    end
    return o;
  endfunction

endpackage

// File: rtl/iir_biquad_tdm_mac.sv
// Shared multiplier with one register stage, then accumulate.
// Products are sign-extended to the accumulator and added or subtracted.
module iir_mac
  import iir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int ACCW = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   issue,
  input  logic                   sub,
  input  logic signed [CW-1:0]   coef,
  input  logic signed [DW-1:0]   opnd,
  output logic signed [ACCW-1:0] acc_next
);

  localparam int PW = DW + CW;

  logic signed [PW-1:0]   prod_d;
  logic signed [PW-1:0]   prod_q;
  logic                   pv_q;
  logic                   ps_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] pext;

  // Full-precision signed product and the next accumulator value.
  always_comb begin
    prod_d   = PW'(coef) * PW'(opnd);
    pext     = {{(ACCW-PW){prod_q[PW-1]}}, prod_q};
    acc_next = acc_q;
    if (pv_q) begin
      acc_next = ps_q ? acc_q - pext : acc_q + pext;
    end
  end

  // Product pipeline stage and accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      ps_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      pv_q   <= issue;
      ps_q   <= sub;
      acc_q  <= clr ? '0 : acc_next;
    end
  end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Direct Form I biquad shared across NCH channels, one MAC.
// Coefficients are snapshotted at accept; history lives per channel.
module iir_biquad_tdm
  import iir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int NCH  = 4,
  parameter int ACCW = 40,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [DW-1:0] y_out,
  output logic                 sat_flag
);

  state_t                 state_q, state_d;
  logic [2:0]             tap_q, tap_d;
  logic                   accept;
  logic signed [CW-1:0]   coef_r [NTAP];
  logic signed [CW-1:0]   cs     [NTAP];
  logic signed [DW-1:0]   xs;
  logic [CHW-1:0]         ch_q;
  logic [CHW-1:0]         chi;
  logic                   ch_ok_q;
  logic signed [DW-1:0]   x1 [NCH];
  logic signed [DW-1:0]   x2 [NCH];
  logic signed [DW-1:0]   y1 [NCH];
  logic signed [DW-1:0]   y2 [NCH];
  logic                   issue;
  logic                   sub;
  logic signed [CW-1:0]   mc;
  logic signed [DW-1:0]   mo;
  logic signed [ACCW-1:0] acc_next;
  logic [63:0]            acc64;
  rnd_t                   rnd;
  logic                   fin;
  logic                   unused_hi;

  // Next state: one accept, five taps, one drain cycle.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    in_ready = (state_q == S_IDLE);
    accept   = in_valid && in_ready;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_MAC;
          tap_d   = TAP_B0;
        end
      end
      S_MAC: begin
        if (tap_q == TAP_A2) state_d = S_DRAIN;
        else                 tap_d   = tap_q + 3'd1;
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and tap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tap_q   <= TAP_B0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  // Coefficient bank, accept-time snapshot and sample latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAP; i++) begin
        coef_r[i] <= '0;
        cs[i]     <= '0;
      end
      xs      <= '0;
      ch_q    <= '0;
      ch_ok_q <= 1'b0;
    end else begin
      for (int i = 0; i < NTAP; i++) begin
        if (coef_we && coef_addr == 3'(i)) coef_r[i] <= coef_data;
      end
      if (accept) begin
        for (int i = 0; i < NTAP; i++) cs[i] <= coef_r[i];
        xs      <= x_in;
        ch_q    <= in_ch;
        ch_ok_q <= (int'(in_ch) < NCH);
      end
    end
  end

  // Operand select for the tap being issued.
  always_comb begin
    mc    = '0;
    mo    = '0;
    chi   = ch_ok_q ? ch_q : '0;
    issue = (state_q == S_MAC);
    sub   = (tap_q == TAP_A1) || (tap_q == TAP_A2);
    case (tap_q)
      TAP_B0:  begin mc = cs[0]; mo = xs;      end
      TAP_B1:  begin mc = cs[1]; mo = x1[chi]; end
      TAP_B2:  begin mc = cs[2]; mo = x2[chi]; end
      TAP_A1:  begin mc = cs[3]; mo = y1[chi]; end
      TAP_A2:  begin mc = cs[4]; mo = y2[chi]; end
      default: ;
    endcase
  end

  iir_mac #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .issue    (issue),
    .sub      (sub),
    .coef     (mc),
    .opnd     (mo),
    .acc_next (acc_next)
  );

  // Final accumulator value rounded and clipped.
  always_comb begin
    acc64     = {{(64-ACCW){acc_next[ACCW-1]}}, acc_next};
    rnd       = sat_round(acc64, FRAC, DW);
    fin       = (state_q == S_DRAIN) && ch_ok_q;
    unused_hi = ^rnd.val[63:DW];
  end

  // Output register and per-channel history update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      y_out     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= fin;
      if (fin) begin
        y_out    <= rnd.val[DW-1:0];
        out_ch   <= ch_q;
        sat_flag <= rnd.sat;
      end
      for (int i = 0; i < NCH; i++) begin
        if (fin && ch_q == CHW'(i)) begin
          x2[i] <= x1[i];
          x1[i] <= xs;
          y2[i] <= y1[i];
          y1[i] <= rnd.val[DW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Directed bench for iir_biquad_tdm, three channels.
// NCH=3 leaves in_ch=3 as an out-of-range channel code.
module tb_iir_biquad_tdm;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int NCH = 3;
  localparam int CHW = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [CHW-1:0]       in_ch;
  logic signed [DW-1:0] x_in;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic signed [DW-1:0] y_out;
  logic                 sat_flag;

  int checks = 0;
  int errors = 0;

  logic ov;
  logic s;
  int   y;
  int   oc;
  int   lat;

  always #5 clk = ~clk;

  iir_biquad_tdm #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (14),
    .NCH  (NCH),
    .ACCW (40)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .x_in      (x_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .y_out     (y_out),
    .sat_flag  (sat_flag)
  );

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    x_in      = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = CW'(d);
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  // Offer one sample, then watch up to cycle t+13 for out_valid.
  task automatic send(input int ch, input int x, output logic v,
                      output int yv, output logic sv,
                      output int cv, output int lv);
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    x_in     = DW'(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    v  = 1'b0;
    yv = 0;
    sv = 1'b0;
    cv = 0;
    lv = 0;
    for (int i = 2; i <= 13; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && !v) begin
        v  = 1'b1;
        yv = int'(y_out);
        sv = sat_flag;
        cv = int'(out_ch);
        lv = i;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, out_valid, sat_flag, out_ch, y_out} !==
        {1'b1, 1'b0, 1'b0, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset rdy=%0b ov=%0b sat=%0b ch=%0d y=%0d need 1 0 0 0 0",
               in_ready, out_valid, sat_flag, out_ch, y_out);
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    wr(0, 16384);
    send(0, 1000, ov, y, s, oc, lat);
    checks++;
    if (!ov || lat != 7) begin
      errors++;
      $display("FAIL pass_latency valid=%0b lat=%0d need 1 7", ov, lat);
    end
    checks++;
    if (y != 1000 || s !== 1'b0 || oc != 0) begin
      errors++;
      $display("FAIL pass_value y=%0d sat=%0b ch=%0d need 1000 0 0", y, s, oc);
    end
    send(2, -1234, ov, y, s, oc, lat);
    checks++;
    if (!ov || y != -1234 || oc != 2) begin
      errors++;
      $display("FAIL pass_ch2 valid=%0b y=%0d ch=%0d need 1 -1234 2", ov, y, oc);
    end
  endtask

  task automatic test_delay();
    int xs[3] = '{500, -300, 700};
    int ex[3] = '{0, 500, -300};
    do_reset();
    wr(1, 16384);
    for (int i = 0; i < 3; i++) begin
      send(0, xs[i], ov, y, s, oc, lat);
      checks++;
      if (!ov || y != ex[i]) begin
        errors++;
        $display("FAIL delay[%0d] valid=%0b y=%0d need y=%0d", i, ov, y, ex[i]);
      end
    end
  endtask

  task automatic test_feedback();
    int ex1[4] = '{1000, 500, 250, 125};
    int ex2[4] = '{1000, 0, 1000, 0};
    do_reset();
    wr(0, 16384);
    wr(3, -8192);
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 1000 : 0, ov, y, s, oc, lat);
      checks++;
      if (!ov || y != ex1[i]) begin
        errors++;
        $display("FAIL fb_a1[%0d] valid=%0b y=%0d need y=%0d", i, ov, y, ex1[i]);
      end
    end
    do_reset();
    wr(0, 16384);
    wr(4, -16384);
    for (int i = 0; i < 4; i++) begin
      send(1, (i == 0) ? 1000 : 0, ov, y, s, oc, lat);
      checks++;
      if (!ov || y != ex2[i]) begin
        errors++;
        $display("FAIL fb_a2[%0d] valid=%0b y=%0d need y=%0d", i, ov, y, ex2[i]);
      end
    end
  endtask

  task automatic test_round();
    int xs[4] = '{3, -3, -1, 1};
    int ex[4] = '{2, -1, 0, 1};
    do_reset();
    wr(0, 8192);
    for (int i = 0; i < 4; i++) begin
      send(0, xs[i], ov, y, s, oc, lat);
      checks++;
      if (!ov || y != ex[i]) begin
        errors++;
        $display("FAIL round[%0d] valid=%0b y=%0d need y=%0d", i, ov, y, ex[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int   xs[3] = '{32767, -32768, 100};
    int   ex[3] = '{32767, -32768, 200};
    logic es[3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    wr(0, 32767);
    for (int i = 0; i < 3; i++) begin
      send(0, xs[i], ov, y, s, oc, lat);
      checks++;
      if (!ov || y != ex[i] || s !== es[i]) begin
        errors++;
        $display("FAIL sat[%0d] valid=%0b y=%0d sat=%0b need y=%0d sat=%0b",
                 i, ov, y, s, ex[i], es[i]);
      end
    end
  endtask

  task automatic test_channels();
    int   cs[5] = '{0, 1, 0, 3, 1};
    int   xs[5] = '{500, 900, 0, 77, 0};
    int   ex[5] = '{0, 0, 500, 0, 900};
    logic ev[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    wr(1, 16384);
    for (int i = 0; i < 5; i++) begin
      send(cs[i], xs[i], ov, y, s, oc, lat);
      checks++;
      if (ov !== ev[i] || (ev[i] && (y != ex[i] || oc != cs[i]))) begin
        errors++;
        $display("FAIL chan[%0d] valid=%0b y=%0d ch=%0d need valid=%0b y=%0d ch=%0d",
                 i, ov, y, oc, ev[i], ex[i], cs[i]);
      end
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    wr(0, 16384);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd8192;
    send(0, 1000, ov, y, s, oc, lat);
    checks++;
    if (!ov || y != 1000) begin
      errors++;
      $display("FAIL snap_old valid=%0b y=%0d need 1000", ov, y);
    end
    send(0, 1000, ov, y, s, oc, lat);
    checks++;
    if (!ov || y != 500) begin
      errors++;
      $display("FAIL snap_new valid=%0b y=%0d need 500", ov, y);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(0, 16384);
    in_valid = 1'b1;
    in_ch    = 2'd0;
    x_in     = 16'sd100;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b11 || y_out !== 16'sd100) begin
      errors++;
      $display("FAIL b2b_first ov=%0b rdy=%0b y=%0d need 1 1 100",
               out_valid, in_ready, y_out);
    end
    in_valid = 1'b1;
    in_ch    = 2'd1;
    x_in     = 16'sd200;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b00 || y_out !== 16'sd100) begin
      errors++;
      $display("FAIL b2b_hold ov=%0b rdy=%0b y=%0d need 0 0 100",
               out_valid, in_ready, y_out);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || y_out !== 16'sd200 || out_ch !== 2'd1) begin
      errors++;
      $display("FAIL b2b_second ov=%0b y=%0d ch=%0d need 1 200 1",
               out_valid, y_out, out_ch);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int nv;
    do_reset();
    wr(0, 16384);
    send(0, 999, ov, y, s, oc, lat);
    in_valid = 1'b1;
    in_ch    = 2'd0;
    x_in     = 16'sd1000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) nv++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (nv != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_quiet pulses=%0d rdy=%0b need 0 1", nv, in_ready);
    end
    send(0, 1234, ov, y, s, oc, lat);
    checks++;
    if (!ov || y != 0) begin
      errors++;
      $display("FAIL abort_coefs valid=%0b y=%0d need 0", ov, y);
    end
    wr(2, 16384);
    send(0, 55, ov, y, s, oc, lat);
    checks++;
    if (!ov || y != 0) begin
      errors++;
      $display("FAIL abort_hist valid=%0b y=%0d need 0", ov, y);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_delay();
    test_feedback();
    test_round();
    test_saturation();
    test_channels();
    test_snapshot();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
